// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the I/D cache memory arbiter.
//   - default block address / data widths
//   - arbiter FSM state encoding
package mem_arbiter_pkg;

  localparam int MA_ADDR_W = 28;   // block address (word address >> 2)
  localparam int MA_DATA_W = 128;  // one cache block per transfer

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    REL   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the I-cache, D-cache and memory-side signals
// around the arbiter.
//   master : arbiter view (drives cache responses and memory requests)
//   slave  : environment view (caches + memory model)
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = MA_ADDR_W,
  parameter int DATA_W = MA_DATA_W
);

  // I-cache
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  // D-cache
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  // memory port
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  i_read, i_addr,
    input  d_read, d_write, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output i_rdata, i_ready,
    output d_rdata, d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output i_read, i_addr,
    output d_read, d_write, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  i_rdata, i_ready,
    input  d_rdata, d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational two-way selector between I and D requests.
//   req_i    : I-cache requesting
//   req_d    : D-cache requesting (read or write-back)
//   last_gnt : previous grant owner (0 = I, 1 = D)
//   pick_d   : 1 = grant D, 0 = grant I (only meaningful when a request is present)
// RR_EN = 1 alternates on a tie; RR_EN = 0 always favours D on a tie.
module mem_arb_pick #(
  parameter bit RR_EN = 1'b1
) (
  input  logic req_i,
  input  logic req_d,
  input  logic last_gnt,
  output logic pick_d
);

  logic tie_pick_d;

  assign tie_pick_d = RR_EN ? ~last_gnt : 1'b1;
  assign pick_d     = req_d & (~req_i | tie_pick_d);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the I-cache and D-cache.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.master (cache request/response + memory port)
// One requester is granted at a time and keeps the grant until mem_ready.
// Memory-side request and cache-side response are decoded from the state
// register; ready/rdata pass through combinationally to the owner only.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; arbitrate requests present at the next edge
// GNT_I | I-cache owns memory port; wait for mem_ready
// GNT_D | D-cache owns memory port; wait for mem_ready
// REL   | one-cycle bubble so the finished cache can drop its request
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = MA_ADDR_W,
  parameter int DATA_W = MA_DATA_W,
  parameter bit RR_EN  = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.master bus
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
  localparam logic [DATA_W-1:0] ZERO_DATA = '0;

  arb_state_t state;
  logic       last_gnt;
  logic       req_d;
  logic       pick_d;

  assign req_d = bus.d_read | bus.d_write;

  mem_arb_pick #(
    .RR_EN (RR_EN)
  ) u_pick (
    .req_i    (bus.i_read),
    .req_d    (req_d),
    .last_gnt (last_gnt),
    .pick_d   (pick_d)
  );

  // last_gnt resets to D so that I wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_read || req_d)
            state <= pick_d ? GNT_D : GNT_I;
        end
        GNT_I: begin
          if (bus.mem_ready) begin
            state    <= REL;
            last_gnt <= 1'b0;
          end
        end
        GNT_D: begin
          if (bus.mem_ready) begin
            state    <= REL;
            last_gnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A granted cache that drops its request early leaves the grant in
  // place but stops driving mem_read/mem_write.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = ZERO_ADDR;
    bus.mem_wdata = ZERO_DATA;
    bus.i_ready   = 1'b0;
    bus.i_rdata   = ZERO_DATA;
    bus.d_ready   = 1'b0;
    bus.d_rdata   = ZERO_DATA;
    case (state)
      GNT_I: begin
        bus.mem_read = bus.i_read;
        bus.mem_addr = bus.i_addr;
        bus.i_ready  = bus.mem_ready;
        bus.i_rdata  = bus.mem_rdata;
      end
      GNT_D: begin
        // write-back wins if the D-cache raises both
        bus.mem_write = bus.d_write;
        bus.mem_read  = bus.d_read & ~bus.d_write;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.d_ready   = bus.mem_ready;
        bus.d_rdata   = bus.mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = MA_ADDR_W;
  localparam int DW = MA_DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: RR_EN=1 instance, index 1: RR_EN=0 instance
  logic          i_read [2];
  logic [AW-1:0] i_addr [2];
  logic          d_read [2];
  logic          d_write [2];
  logic [AW-1:0] d_addr [2];
  logic [DW-1:0] d_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          mem_ready [2];

  logic          i_ready_w [2];
  logic [DW-1:0] i_rdata_w [2];
  logic          d_ready_w [2];
  logic [DW-1:0] d_rdata_w [2];
  logic          mem_read_w [2];
  logic          mem_write_w [2];
  logic [AW-1:0] mem_addr_w [2];
  logic [DW-1:0] mem_wdata_w [2];

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus0.i_read    = i_read[0];
  assign bus0.i_addr    = i_addr[0];
  assign bus0.d_read    = d_read[0];
  assign bus0.d_write   = d_write[0];
  assign bus0.d_addr    = d_addr[0];
  assign bus0.d_wdata   = d_wdata[0];
  assign bus0.mem_rdata = mem_rdata[0];
  assign bus0.mem_ready = mem_ready[0];
  assign bus1.i_read    = i_read[1];
  assign bus1.i_addr    = i_addr[1];
  assign bus1.d_read    = d_read[1];
  assign bus1.d_write   = d_write[1];
  assign bus1.d_addr    = d_addr[1];
  assign bus1.d_wdata   = d_wdata[1];
  assign bus1.mem_rdata = mem_rdata[1];
  assign bus1.mem_ready = mem_ready[1];

  assign i_ready_w[0]   = bus0.i_ready;
  assign i_rdata_w[0]   = bus0.i_rdata;
  assign d_ready_w[0]   = bus0.d_ready;
  assign d_rdata_w[0]   = bus0.d_rdata;
  assign mem_read_w[0]  = bus0.mem_read;
  assign mem_write_w[0] = bus0.mem_write;
  assign mem_addr_w[0]  = bus0.mem_addr;
  assign mem_wdata_w[0] = bus0.mem_wdata;
  assign i_ready_w[1]   = bus1.i_ready;
  assign i_rdata_w[1]   = bus1.i_rdata;
  assign d_ready_w[1]   = bus1.d_ready;
  assign d_rdata_w[1]   = bus1.d_rdata;
  assign mem_read_w[1]  = bus1.mem_read;
  assign mem_write_w[1] = bus1.mem_write;
  assign mem_addr_w[1]  = bus1.mem_addr;
  assign mem_wdata_w[1] = bus1.mem_wdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.master)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  typedef struct packed {
    logic          is_d;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int u, input bit is_d, input logic [DW-1:0] rdata);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    if (u == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // scoreboard monitor: every ready pulse must match a queued expectation
  task automatic mon(input int u);
    exp_t e;
    bit   have;
    if (!(i_ready_w[u] || d_ready_w[u])) return;
    chk("ready_onehot", DW'(i_ready_w[u] & d_ready_w[u]), '0);
    have = (u == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready u%0d: got i_ready=%b d_ready=%b, expected no pulse",
               u, i_ready_w[u], d_ready_w[u]);
      return;
    end
    e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    chk("ready_owner", DW'(d_ready_w[u]), DW'(e.is_d));
    chk("owner_rdata", e.is_d ? d_rdata_w[u] : i_rdata_w[u], e.rdata);
    chk("other_rdata", e.is_d ? i_rdata_w[u] : d_rdata_w[u], '0);
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(input int u, input bit ex_rd, input bit ex_wr,
                         input logic [AW-1:0] ex_addr, input logic [DW-1:0] ex_wdata);
    chk("mem_read",  DW'(mem_read_w[u]),  DW'(ex_rd));
    chk("mem_write", DW'(mem_write_w[u]), DW'(ex_wr));
    chk("mem_addr",  DW'(mem_addr_w[u]),  DW'(ex_addr));
    chk("mem_wdata", mem_wdata_w[u], ex_wdata);
  endtask

  task automatic chk_all_zero(input int u);
    chk_mem(u, 1'b0, 1'b0, '0, '0);
    chk("i_ready_zero", DW'(i_ready_w[u]), '0);
    chk("d_ready_zero", DW'(d_ready_w[u]), '0);
    chk("i_rdata_zero", i_rdata_w[u], '0);
    chk("d_rdata_zero", d_rdata_w[u], '0);
  endtask

  // Called in an IDLE cycle with the requests already driven.
  task automatic txn(input int u, input bit own_d, input bit ex_rd, input bit ex_wr,
                     input logic [AW-1:0] ex_addr, input logic [DW-1:0] ex_wdata,
                     input int lat, input logic [DW-1:0] rdata);
    chk("idle_no_req", DW'({mem_read_w[u], mem_write_w[u]}), '0);
    tick();
    for (int k = 0; k <= lat; k++) begin
      chk_mem(u, ex_rd, ex_wr, ex_addr, ex_wdata);
      if (k < lat) tick();
    end
    mem_ready[u] = 1'b1;
    mem_rdata[u] = rdata;
    push_exp(u, own_d, rdata);
    tick();
    mem_ready[u] = 1'b0;
    mem_rdata[u] = '0;
    if (own_d) begin
      d_read[u]  = 1'b0;
      d_write[u] = 1'b0;
    end else begin
      i_read[u] = 1'b0;
    end
    chk("rel_no_req", DW'({mem_read_w[u], mem_write_w[u]}), '0);
    tick();
    chk("post_rel_no_req", DW'({mem_read_w[u], mem_write_w[u]}), '0);
  endtask

  localparam logic [DW-1:0] A5  = {16{8'hA5}};
  localparam logic [DW-1:0] WD1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DW-1:0] WD2 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002;
  localparam logic [DW-1:0] RD1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    for (int u = 0; u < 2; u++) begin
      i_read[u] = 1'b0; i_addr[u] = '0;
      d_read[u] = 1'b0; d_write[u] = 1'b0; d_addr[u] = '0; d_wdata[u] = '0;
      mem_rdata[u] = '0; mem_ready[u] = 1'b0;
    end

    // reset with a tie pending on unit 0: outputs must stay 0
    i_read[0] = 1'b1; i_addr[0] = 28'h0000100;
    d_write[0] = 1'b1; d_addr[0] = 28'h0000200; d_wdata[0] = WD1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero(0);
    chk_all_zero(1);
    rst_n = 1'b1;

    // RR: tie at reset exit -> I first, then D (alone), then tie I, tie D
    txn(0, 1'b0, 1'b1, 1'b0, 28'h0000100, '0, 1, RD1);
    txn(0, 1'b1, 1'b0, 1'b1, 28'h0000200, WD1, 2, '0);
    i_read[0] = 1'b1; i_addr[0] = 28'h0000300;
    d_write[0] = 1'b1; d_addr[0] = 28'h0000400; d_wdata[0] = WD2;
    txn(0, 1'b0, 1'b1, 1'b0, 28'h0000300, '0, 0, A5);
    i_read[0] = 1'b1; i_addr[0] = 28'h0000500;
    txn(0, 1'b1, 1'b0, 1'b1, 28'h0000400, WD2, 1, '0);
    txn(0, 1'b0, 1'b1, 1'b0, 28'h0000500, '0, 0, WD1);

    // I-only read, memory answers 4 cycles after the request appears
    i_read[0] = 1'b1; i_addr[0] = 28'h0000010;
    txn(0, 1'b0, 1'b1, 1'b0, 28'h0000010, '0, 4, A5);

    // d_read and d_write together: write wins, same-cycle ready
    d_read[0] = 1'b1; d_write[0] = 1'b1; d_addr[0] = 28'hABCDEF0; d_wdata[0] = WD2;
    txn(0, 1'b1, 1'b0, 1'b1, 28'hABCDEF0, WD2, 0, RD1);

    // mem_ready in IDLE is ignored
    mem_ready[0] = 1'b1; mem_rdata[0] = A5;
    #1;
    chk("idle_ready_ignored", DW'({i_ready_w[0], d_ready_w[0]}), '0);
    tick();
    mem_ready[0] = 1'b0; mem_rdata[0] = '0;
    chk("idle_ready_no_req", DW'({mem_read_w[0], mem_write_w[0]}), '0);

    // granted I drops its request early: grant held, mem_read deasserted
    i_read[0] = 1'b1; i_addr[0] = 28'h0000777;
    tick();
    chk_mem(0, 1'b1, 1'b0, 28'h0000777, '0);
    i_read[0] = 1'b0;
    #1;
    chk_mem(0, 1'b0, 1'b0, 28'h0000777, '0);
    tick();
    chk_mem(0, 1'b0, 1'b0, 28'h0000777, '0);
    mem_ready[0] = 1'b1; mem_rdata[0] = WD2;
    push_exp(0, 1'b0, WD2);
    tick();
    mem_ready[0] = 1'b0; mem_rdata[0] = '0;
    chk("drop_rel_no_req", DW'({mem_read_w[0], mem_write_w[0]}), '0);
    tick();

    // long memory stall on a D read: 50 cycles, all stable
    d_read[0] = 1'b1; d_addr[0] = 28'h5555555; d_wdata[0] = WD1;
    txn(0, 1'b1, 1'b1, 1'b0, 28'h5555555, WD1, 50, RD1);

    // fixed priority: D wins three ties in a row, I served afterwards
    i_read[1] = 1'b1; i_addr[1] = 28'h0000999;
    for (int j = 0; j < 3; j++) begin
      d_read[1] = 1'b1; d_addr[1] = AW'(28'h0000A00 + j);
      txn(1, 1'b1, 1'b1, 1'b0, AW'(28'h0000A00 + j), '0, 1, DW'(j + 1));
    end
    txn(1, 1'b0, 1'b1, 1'b0, 28'h0000999, '0, 1, A5);

    // async reset during GNT_D before mem_ready
    d_write[0] = 1'b1; d_addr[0] = 28'h0000F00; d_wdata[0] = WD1;
    tick();
    chk_mem(0, 1'b0, 1'b1, 28'h0000F00, WD1);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero(0);
    d_write[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_all_zero(0);
    i_read[0] = 1'b1; i_addr[0] = 28'h0000123;
    txn(0, 1'b0, 1'b1, 1'b0, 28'h0000123, '0, 2, RD1);

    repeat (2) tick();
    chk("sb_drain0", DW'(exp_q0.size()), '0);
    chk("sb_drain1", DW'(exp_q1.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, expected completion");
    $fatal(1, "timeout");
  end

endmodule
